axi_lite_client_arbiter: RTL and testbench

Round-robin arbiter that shares one `axi_lite_master` user port among `NUM_CLIENTS` local requesters. It sits between the clients and the master's `wr_*`/`rd_*` user interface. It grants one client at a time and latches that client's command. It then issues a single-cycle `wr_req` or `rd_req`, waits for the matching done pulse, and returns the response to the granted client. Only one transaction, read or write, is outstanding at a time.

---
 rtl/axi_lite_client_arbiter_pkg.sv | 17 +
 rtl/rr_priority_pick.sv | 37 +++
 rtl/axi_lite_client_arbiter.sv | 179 +++++++++++++++++
 tb/tb_axi_lite_client_arbiter.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_client_arbiter_pkg.sv
// Shared types and constants for the AXI-Lite client arbiter.
// Carries the xRESP encodings and the arbiter's local FSM state encoding.
package axi_lite_client_arbiter_pkg;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_EXOKAY = 2'b01;
   localparam logic [1:0] RESP_SLVERR = 2'b10;
   localparam logic [1:0] RESP_DECERR = 2'b11;

   typedef enum logic [1:0] {
      StIdle,
      StIssue,
      StWait,
      StDone
   } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester found after last_gnt_i, with wrap.
// Returns a one-hot pick and its index; both are zero when nothing requests.
module rr_priority_pick
   import axi_lite_client_arbiter_pkg::*;
#(
   parameter  int unsigned N  = 4,
   localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  req_i,
   input  logic [IW-1:0] last_gnt_i,
   output logic [N-1:0]  pick_o,
   output logic [IW-1:0] pick_idx_o
);

   int unsigned   cand;
   logic [IW-1:0] cand_idx;
   logic          found;

   always_comb begin
      pick_o     = '0;
      pick_idx_o = '0;
      found      = 1'b0;
      cand       = 0;
      cand_idx   = '0;
      // Offsets 1..N so the previous winner is considered last.
      for (int unsigned i = 1; i <= N; i++) begin
         cand     = (32'(last_gnt_i) + i) % N;
         cand_idx = IW'(cand);
         if (!found && req_i[cand_idx]) begin
            found            = 1'b1;
            pick_o[cand_idx] = 1'b1;
            pick_idx_o       = cand_idx;
         end
      end
   end

endmodule

// File: rtl/axi_lite_client_arbiter.sv
// Round-robin arbiter sharing one AXI-Lite master user port among NUM_CLIENTS requesters.
// One transaction in flight at a time; every output is a flop.
module axi_lite_client_arbiter
   import axi_lite_client_arbiter_pkg::*;
#(
   parameter int unsigned NUM_CLIENTS = 4,
   parameter int unsigned ADDR_WIDTH  = 32,
   parameter int unsigned DATA_WIDTH  = 32
) (
   input  logic                                  aclk,
   input  logic                                  aresetn,
   input  logic [NUM_CLIENTS-1:0]                cli_req,
   input  logic [NUM_CLIENTS-1:0]                cli_we,
   input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0]     cli_addr,
   input  logic [NUM_CLIENTS*DATA_WIDTH-1:0]     cli_wdata,
   input  logic [NUM_CLIENTS*DATA_WIDTH/8-1:0]   cli_wstrb,
   output logic [NUM_CLIENTS-1:0]                cli_ack,
   output logic [DATA_WIDTH-1:0]                 cli_rdata,
   output logic [1:0]                            cli_resp,
   output logic [NUM_CLIENTS-1:0]                cli_gnt,
   output logic                                  busy,
   output logic                                  m_wr_req,
   output logic                                  m_rd_req,
   output logic [ADDR_WIDTH-1:0]                 m_wr_addr,
   output logic [ADDR_WIDTH-1:0]                 m_rd_addr,
   output logic [DATA_WIDTH-1:0]                 m_wr_data,
   output logic [DATA_WIDTH/8-1:0]               m_wr_strb,
   input  logic                                  m_wr_done,
   input  logic                                  m_rd_done,
   input  logic [1:0]                            m_wr_resp,
   input  logic [1:0]                            m_rd_resp,
   input  logic [DATA_WIDTH-1:0]                 m_rd_data
);

   localparam int unsigned IW     = $clog2(NUM_CLIENTS);
   localparam int unsigned STRB_W = DATA_WIDTH / 8;

   arb_state_e               state_q, state_d;
   logic [IW-1:0]            last_gnt_q, last_gnt_d;
   logic [IW-1:0]            gnt_idx_q, gnt_idx_d;
   logic                     we_q, we_d;
   logic [NUM_CLIENTS-1:0]   cli_ack_q, cli_ack_d;
   logic [DATA_WIDTH-1:0]    cli_rdata_q, cli_rdata_d;
   logic [1:0]               cli_resp_q, cli_resp_d;
   logic [NUM_CLIENTS-1:0]   cli_gnt_q, cli_gnt_d;
   logic                     busy_q, busy_d;
   logic                     m_wr_req_q, m_wr_req_d;
   logic                     m_rd_req_q, m_rd_req_d;
   logic [ADDR_WIDTH-1:0]    m_wr_addr_q, m_wr_addr_d;
   logic [ADDR_WIDTH-1:0]    m_rd_addr_q, m_rd_addr_d;
   logic [DATA_WIDTH-1:0]    m_wr_data_q, m_wr_data_d;
   logic [STRB_W-1:0]        m_wr_strb_q, m_wr_strb_d;

   logic [NUM_CLIENTS-1:0]   pick;
   logic [IW-1:0]            pick_idx;
   int unsigned              sel;

   rr_priority_pick #(
      .N (NUM_CLIENTS)
   ) u_pick (
      .req_i      (cli_req),
      .last_gnt_i (last_gnt_q),
      .pick_o     (pick),
      .pick_idx_o (pick_idx)
   );

   always_comb begin
      state_d     = state_q;
      last_gnt_d  = last_gnt_q;
      gnt_idx_d   = gnt_idx_q;
      we_d        = we_q;
      cli_ack_d   = '0;
      cli_rdata_d = cli_rdata_q;
      cli_resp_d  = cli_resp_q;
      cli_gnt_d   = cli_gnt_q;
      busy_d      = busy_q;
      m_wr_req_d  = 1'b0;
      m_rd_req_d  = 1'b0;
      m_wr_addr_d = m_wr_addr_q;
      m_rd_addr_d = m_rd_addr_q;
      m_wr_data_d = m_wr_data_q;
      m_wr_strb_d = m_wr_strb_q;
      sel         = 32'(pick_idx);

      unique case (state_q)
         StIdle: begin
            if (|cli_req) begin
               state_d   = StIssue;
               gnt_idx_d = pick_idx;
               cli_gnt_d = pick;
               busy_d    = 1'b1;
               we_d      = cli_we[pick_idx];
               // Command is captured straight into the master-facing flops so the
               // client may drop its fields once granted.
               if (cli_we[pick_idx]) begin
                  m_wr_req_d  = 1'b1;
                  m_wr_addr_d = cli_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
                  m_wr_data_d = cli_wdata[sel*DATA_WIDTH +: DATA_WIDTH];
                  m_wr_strb_d = cli_wstrb[sel*STRB_W +: STRB_W];
               end else begin
                  m_rd_req_d  = 1'b1;
                  m_rd_addr_d = cli_addr[sel*ADDR_WIDTH +: ADDR_WIDTH];
               end
            end
         end
         StIssue: begin
            last_gnt_d = gnt_idx_q;
            state_d    = StWait;
         end
         StWait: begin
            if (we_q && m_wr_done) begin
               cli_resp_d = m_wr_resp;
               cli_ack_d  = cli_gnt_q;
               state_d    = StDone;
            end else if (!we_q && m_rd_done) begin
               cli_rdata_d = m_rd_data;
               cli_resp_d  = m_rd_resp;
               cli_ack_d   = cli_gnt_q;
               state_d     = StDone;
            end
         end
         StDone: begin
            cli_gnt_d = '0;
            busy_d    = 1'b0;
            state_d   = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q     <= StIdle;
         last_gnt_q  <= IW'(NUM_CLIENTS - 1);
         gnt_idx_q   <= '0;
         we_q        <= 1'b0;
         cli_ack_q   <= '0;
         cli_rdata_q <= '0;
         cli_resp_q  <= '0;
         cli_gnt_q   <= '0;
         busy_q      <= 1'b0;
         m_wr_req_q  <= 1'b0;
         m_rd_req_q  <= 1'b0;
         m_wr_addr_q <= '0;
         m_rd_addr_q <= '0;
         m_wr_data_q <= '0;
         m_wr_strb_q <= '0;
      end else begin
         state_q     <= state_d;
         last_gnt_q  <= last_gnt_d;
         gnt_idx_q   <= gnt_idx_d;
         we_q        <= we_d;
         cli_ack_q   <= cli_ack_d;
         cli_rdata_q <= cli_rdata_d;
         cli_resp_q  <= cli_resp_d;
         cli_gnt_q   <= cli_gnt_d;
         busy_q      <= busy_d;
         m_wr_req_q  <= m_wr_req_d;
         m_rd_req_q  <= m_rd_req_d;
         m_wr_addr_q <= m_wr_addr_d;
         m_rd_addr_q <= m_rd_addr_d;
         m_wr_data_q <= m_wr_data_d;
         m_wr_strb_q <= m_wr_strb_d;
      end
   end

   assign cli_ack   = cli_ack_q;
   assign cli_rdata = cli_rdata_q;
   assign cli_resp  = cli_resp_q;
   assign cli_gnt   = cli_gnt_q;
   assign busy      = busy_q;
   assign m_wr_req  = m_wr_req_q;
   assign m_rd_req  = m_rd_req_q;
   assign m_wr_addr = m_wr_addr_q;
   assign m_rd_addr = m_rd_addr_q;
   assign m_wr_data = m_wr_data_q;
   assign m_wr_strb = m_wr_strb_q;

endmodule

// File: tb/tb_axi_lite_client_arbiter.sv
// Scoreboard bench: randomized clients and a behavioural master; a monitor checks
// every issue against a round-robin reference and every ack against queued expectations.
module tb_axi_lite_client_arbiter;
   import axi_lite_client_arbiter_pkg::*;

   localparam int N = 4;

   logic         aclk, aresetn;
   logic [3:0]   cli_req, cli_we;
   logic [127:0] cli_addr, cli_wdata;
   logic [15:0]  cli_wstrb;
   logic [3:0]   cli_ack, cli_gnt;
   logic [31:0]  cli_rdata;
   logic [1:0]   cli_resp;
   logic         busy, m_wr_req, m_rd_req;
   logic [31:0]  m_wr_addr, m_rd_addr, m_wr_data, m_rd_data;
   logic [3:0]   m_wr_strb;
   logic         m_wr_done, m_rd_done;
   logic [1:0]   m_wr_resp, m_rd_resp;

   axi_lite_client_arbiter #(
      .NUM_CLIENTS (4),
      .ADDR_WIDTH  (32),
      .DATA_WIDTH  (32)
   ) dut (
      .aclk      (aclk),
      .aresetn   (aresetn),
      .cli_req   (cli_req),
      .cli_we    (cli_we),
      .cli_addr  (cli_addr),
      .cli_wdata (cli_wdata),
      .cli_wstrb (cli_wstrb),
      .cli_ack   (cli_ack),
      .cli_rdata (cli_rdata),
      .cli_resp  (cli_resp),
      .cli_gnt   (cli_gnt),
      .busy      (busy),
      .m_wr_req  (m_wr_req),
      .m_rd_req  (m_rd_req),
      .m_wr_addr (m_wr_addr),
      .m_rd_addr (m_rd_addr),
      .m_wr_data (m_wr_data),
      .m_wr_strb (m_wr_strb),
      .m_wr_done (m_wr_done),
      .m_rd_done (m_rd_done),
      .m_wr_resp (m_wr_resp),
      .m_rd_resp (m_rd_resp),
      .m_rd_data (m_rd_data)
   );

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   typedef struct {
      int          cli;
      logic [31:0] rdata;
      logic [1:0]  resp;
      int          cyc;
   } exp_t;

   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   logic [3:0]  snap_req = '0;
   int          model_last = N - 1;
   int          outstanding = 0;
   int          issue_q[$];
   int          grant_log[$];
   exp_t        sb_q[$];
   logic [31:0] exp_rdata = '0;
   logic        c_we[N];
   logic [31:0] c_addr[N], c_wdata[N];
   logic [3:0]  c_strb[N];
   int          m_lat_force = 0;
   bit          resp_forced = 1'b0;
   logic [1:0]  f_resp = '0;
   logic [31:0] f_rdata = '0;
   bit          mbusy = 1'b0;

   always @(posedge aclk) begin
      cyc      <= cyc + 1;
      snap_req <= cli_req;
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   function automatic int rr_pick(input int last, input logic [3:0] req);
      for (int i = 1; i <= N; i++) begin
         int c;
         c = (last + i) % N;
         if (req[c]) return c;
      end
      return -1;
   endfunction

   // Behavioural master: answers each request after a latency with a done pulse.
   initial begin
      int          mcnt;
      bit          mwe;
      logic [1:0]  r;
      logic [31:0] d;
      exp_t        e;
      m_wr_done = 1'b0; m_rd_done = 1'b0;
      m_wr_resp = '0; m_rd_resp = '0; m_rd_data = '0;
      mcnt = 0; mwe = 1'b0;
      forever begin
         @(negedge aclk);
         m_wr_done = 1'b0;
         m_rd_done = 1'b0;
         if (!aresetn) begin
            mbusy = 1'b0;
            continue;
         end
         if (mbusy) begin
            mcnt--;
            if (mcnt <= 0) begin
               r = resp_forced ? f_resp : 2'($urandom_range(0, 3));
               d = resp_forced ? f_rdata : $urandom;
               if (mwe) begin
                  m_wr_done = 1'b1; m_wr_resp = r; m_rd_data = $urandom;
               end else begin
                  m_rd_done = 1'b1; m_rd_resp = r; m_rd_data = d;
               end
               e.cli   = (issue_q.size() > 0) ? issue_q.pop_front() : -1;
               e.resp  = r;
               if (!mwe) exp_rdata = d;
               e.rdata = exp_rdata;
               e.cyc   = cyc;
               sb_q.push_back(e);
               mbusy = 1'b0;
            end
         end else if (m_wr_req || m_rd_req) begin
            mbusy = 1'b1;
            mwe   = m_wr_req;
            mcnt  = (m_lat_force > 0) ? m_lat_force : $urandom_range(1, 5);
         end
      end
   end

   // Monitor: checks issues against the round-robin reference, acks against the scoreboard.
   initial begin
      bit   req_seen;
      int   ex;
      exp_t e;
      forever begin
         @(negedge aclk);
         if (!aresetn) continue;
         req_seen = m_wr_req || m_rd_req;
         if (outstanding > 0) chk("busy_active", 64'(busy), 64'd1);
         else if (!req_seen) begin
            chk("idle_busy", 64'(busy), 64'd0);
            chk("idle_gnt", 64'(cli_gnt), 64'd0);
         end
         if (req_seen) begin
            chk("req_overlap", 64'(outstanding), 64'd0);
            chk("req_excl", 64'(m_wr_req & m_rd_req), 64'd0);
            ex = rr_pick(model_last, snap_req);
            chk("grant", 64'(cli_gnt), (ex >= 0) ? (64'd1 << ex) : 64'd0);
            if (ex >= 0) begin
               chk("req_kind", 64'(m_wr_req), 64'(c_we[ex]));
               if (c_we[ex]) begin
                  chk("wr_addr", 64'(m_wr_addr), 64'(c_addr[ex]));
                  chk("wr_data", 64'(m_wr_data), 64'(c_wdata[ex]));
                  chk("wr_strb", 64'(m_wr_strb), 64'(c_strb[ex]));
               end else begin
                  chk("rd_addr", 64'(m_rd_addr), 64'(c_addr[ex]));
               end
               model_last = ex;
               issue_q.push_back(ex);
               grant_log.push_back(ex);
            end
            outstanding++;
         end
         if (|cli_ack) begin
            if (sb_q.size() == 0) begin
               chk("ack_unexpected", 64'(cli_ack), 64'd0);
            end else begin
               e = sb_q.pop_front();
               chk("ack", 64'(cli_ack), (e.cli >= 0) ? (64'd1 << e.cli) : 64'd0);
               chk("resp", 64'(cli_resp), 64'(e.resp));
               chk("rdata", 64'(cli_rdata), 64'(e.rdata));
               chk("ack_timing", 64'(cyc), 64'(e.cyc + 1));
            end
            if (outstanding > 0) outstanding--;
         end
      end
   end

   task automatic issue(input int c, input logic we, input logic [31:0] a,
                        input logic [31:0] d, input logic [3:0] s);
      c_we[c] = we; c_addr[c] = a; c_wdata[c] = d; c_strb[c] = s;
      cli_we[c] = we;
      cli_addr[c*32 +: 32]  = a;
      cli_wdata[c*32 +: 32] = d;
      cli_wstrb[c*4 +: 4]   = s;
      cli_req[c] = 1'b1;
   endtask

   task automatic issue_rand(input int c);
      issue(c, 1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)));
   endtask

   // Called once per negedge: clients drop (or renew) on ack and may raise new requests.
   task automatic client_step(input int p_new, input int p_keep);
      for (int c = 0; c < N; c++) begin
         if (cli_req[c] && cli_ack[c]) begin
            if (int'($urandom_range(0, 99)) < p_keep) issue_rand(c);
            else cli_req[c] = 1'b0;
         end else if (!cli_req[c] && int'($urandom_range(0, 99)) < p_new) begin
            issue_rand(c);
         end
      end
   endtask

   task automatic wait_idle(input int budget);
      bit done;
      done = 1'b0;
      for (int i = 0; i < budget && !done; i++) begin
         @(negedge aclk);
         client_step(0, 0);
         if (cli_req == 0 && sb_q.size() == 0 && outstanding == 0 && !busy && !mbusy)
            done = 1'b1;
      end
      chk("drain_timeout", 64'(done), 64'd1);
   endtask

   task automatic do_reset();
      @(negedge aclk);
      aresetn = 1'b0;
      cli_req = '0;
      #1;
      chk("rst_ack", 64'(cli_ack), 64'd0);
      chk("rst_gnt", 64'(cli_gnt), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_req", 64'({m_wr_req, m_rd_req}), 64'd0);
      chk("rst_addr", {m_wr_addr, m_rd_addr}, 64'd0);
      chk("rst_data", {m_wr_data, 28'd0, m_wr_strb}, 64'd0);
      chk("rst_rsp", {cli_rdata, 30'd0, cli_resp}, 64'd0);
      issue_q.delete();
      sb_q.delete();
      model_last  = N - 1;
      outstanding = 0;
      exp_rdata   = '0;
      repeat (2) @(negedge aclk);
      aresetn = 1'b1;
   endtask

   initial begin
      int  ls;
      bit  hit;
      aresetn = 1'b0;
      cli_req = '0; cli_we = '0; cli_addr = '0; cli_wdata = '0; cli_wstrb = '0;
      for (int c = 0; c < N; c++) begin
         c_we[c] = 1'b0; c_addr[c] = '0; c_wdata[c] = '0; c_strb[c] = '0;
      end
      do_reset();

      // Single write from client 2, slave answers OKAY.
      @(negedge aclk);
      resp_forced = 1'b1; f_resp = RESP_OKAY;
      issue(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
      wait_idle(50);

      // Single read from client 1, slave returns data with SLVERR.
      @(negedge aclk);
      f_rdata = 32'hCAFEF00D; f_resp = RESP_SLVERR;
      issue(1, 1'b0, 32'h20, 32'h0, 4'h0);
      wait_idle(50);
      resp_forced = 1'b0;

      // Fairness: all clients request continuously from reset.
      do_reset();
      ls = grant_log.size();
      repeat (60) begin
         @(negedge aclk);
         client_step(100, 100);
      end
      wait_idle(300);
      chk("fair_count", 64'(grant_log.size() >= ls + 6), 64'd1);
      if (grant_log.size() >= ls + 6)
         for (int k = 0; k < 6; k++) chk("fair_order", 64'(grant_log[ls+k]), 64'(k % N));

      // Contention after last_gnt = 0: client 3 must precede client 0.
      do_reset();
      @(negedge aclk);
      issue_rand(0);
      wait_idle(50);
      @(negedge aclk);
      issue_rand(0);
      issue_rand(3);
      ls = grant_log.size();
      wait_idle(100);
      chk("cont_count", 64'(grant_log.size() >= ls + 2), 64'd1);
      if (grant_log.size() >= ls + 2) begin
         chk("cont_first", 64'(grant_log[ls]), 64'd3);
         chk("cont_second", 64'(grant_log[ls+1]), 64'd0);
      end

      // Stall: first transaction takes 20 cycles while others wait.
      @(negedge aclk);
      m_lat_force = 20;
      issue_rand(0); issue_rand(1); issue_rand(2);
      repeat (4) @(negedge aclk);
      m_lat_force = 0;
      repeat (10) @(negedge aclk);
      chk("stall_busy", 64'(busy), 64'd1);
      chk("stall_pending", 64'(cli_req), 64'h7);
      wait_idle(200);

      // Reset in WAIT: abort with no ack, client 0 wins first afterwards.
      @(negedge aclk);
      m_lat_force = 20;
      issue_rand(1); issue_rand(2);
      hit = 1'b0;
      for (int i = 0; i < 20 && !hit; i++) begin
         @(negedge aclk);
         hit = mbusy;
      end
      chk("midop_reached", 64'(hit), 64'd1);
      repeat (5) @(negedge aclk);
      do_reset();
      m_lat_force = 0;
      @(negedge aclk);
      for (int c = 0; c < N; c++) issue_rand(c);
      ls = grant_log.size();
      wait_idle(200);
      chk("post_rst_first", 64'(grant_log.size() > ls ? grant_log[ls] : -1), 64'd0);

      // Randomized traffic.
      repeat (1500) begin
         @(negedge aclk);
         client_step(30, 25);
      end
      wait_idle(500);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
